// File: rtl/ntru_result_reader_if.sv
// Reader-side bundle: run control, result-memory read port and the AXI4-Stream master.
interface ntru_result_reader_if #(
  parameter int ADDR_W  = 10,
  parameter int COEF_W  = 11,
  parameter int TDATA_W = 32
);
  logic               start;
  logic               busy;
  logic               done;
  logic               mem_read;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COEF_W-1:0]  mem_eo;
  logic [TDATA_W-1:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;

  modport master (
    input  start, mem_eo, m_axis_tready,
    output busy, done, mem_read, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output start, mem_eo, m_axis_tready,
    input  busy, done, mem_read, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/ntru_result_reader.sv
// Streams the product polynomial out of the banked result memories, one coefficient per beat, first beat 3 cycles after start.
// Reads are issued only against free FIFO credit, so tready stalls hold the stream without loss.
module ntru_result_reader #(
  parameter int N          = 541,
  parameter int q          = 2048,
  parameter int M          = 2,
  parameter int TDATA_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  resetn,
  ntru_result_reader_if.master bus
);
  localparam int COEF_W  = $clog2(q);
  localparam int ROWS    = (N + M - 1) / M;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BANK_W  = (M > 1) ? $clog2(M) : 0;
  localparam int BANK_WI = (M > 1) ? BANK_W : 1;
  localparam int ADDR_W  = ROW_W + BANK_W;
  localparam int CNT_W   = $clog2(N + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]   LAST_K   = CNT_W'(N - 1);
  localparam logic [BANK_WI-1:0] BANK_MAX = BANK_WI'(M - 1);
  localparam logic [FCNT_W:0]    DEPTH_C  = (FCNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [ROW_W-1:0]   r_row;
  logic [BANK_WI-1:0] r_bank;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_inflight;
  logic               r_infl_last;

  logic [COEF_W-1:0]     r_fdat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_flast;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [FCNT_W-1:0]     r_fcnt;

  logic              w_fvld;
  logic              w_pop;
  logic              w_last_out;
  logic [FCNT_W:0]   w_occ;
  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;

  assign w_fvld     = (r_fcnt != '0);
  assign w_pop      = w_fvld && bus.m_axis_tready;
  assign w_last_out = w_fvld && r_flast[r_rptr];

  // A beat leaving this cycle frees its slot in time for the read issued now, which keeps depth 2 at full rate.
  assign w_occ   = {1'b0, r_fcnt} + {{FCNT_W{1'b0}}, r_inflight} - {{FCNT_W{1'b0}}, w_pop};
  assign w_issue = (r_state == S_ISSUE) && (w_occ < DEPTH_C);

  generate
    if (BANK_W == 0) begin : g_nobank
      assign w_addr = r_row;
    end else begin : g_bank
      assign w_addr = {r_row, r_bank};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_row       <= '0;
      r_bank      <= '0;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_cnt == LAST_K);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_bank  <= '0;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          // The address stays on N-1 after the final issue rather than stepping past the polynomial.
          if (w_issue) begin
            if (r_cnt == LAST_K) begin
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_bank == BANK_MAX) begin
                r_bank <= '0;
                r_row  <= r_row + 1'b1;
              end else begin
                r_bank <= r_bank + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last_out) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fcnt  <= '0;
      r_flast <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fdat[i] <= '0;
      end
    end else begin
      if (r_inflight) begin
        r_fdat[r_wptr]  <= bus.mem_eo;
        r_flast[r_wptr] <= r_infl_last;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_fcnt <= r_fcnt + {{PTR_W{1'b0}}, r_inflight} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (r_fcnt <= FCNT_W'(FIFO_DEPTH));
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.mem_read      = r_busy;
  assign bus.mem_addr      = w_addr;
  assign bus.m_axis_tvalid = w_fvld;
  assign bus.m_axis_tlast  = w_last_out;
  assign bus.m_axis_tdata  = w_fvld ? TDATA_W'(r_fdat[r_rptr]) : '0;
endmodule

// File: tb/tb_ntru_result_reader.sv
// Directed bench: four reader configurations sharing one clock, each fed by a registered memory model.
module tb_ntru_result_reader;
  localparam int N_C = 541;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic rdy = 1'b1;
  int   sel = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_addr [16];

  always #5 clk = ~clk;

  ntru_result_reader_if #(.ADDR_W(3),  .COEF_W(11), .TDATA_W(32)) a_if ();
  ntru_result_reader_if #(.ADDR_W(4),  .COEF_W(11), .TDATA_W(32)) b_if ();
  ntru_result_reader_if #(.ADDR_W(10), .COEF_W(11), .TDATA_W(32)) c_if ();
  ntru_result_reader_if #(.ADDR_W(4),  .COEF_W(11), .TDATA_W(32)) d_if ();

  ntru_result_reader #(.N(5),   .q(2048), .M(2), .TDATA_W(32), .FIFO_DEPTH(4))
    u_a (.clk(clk), .resetn(resetn), .bus(a_if.master));
  ntru_result_reader #(.N(7),   .q(2048), .M(3), .TDATA_W(32), .FIFO_DEPTH(4))
    u_b (.clk(clk), .resetn(resetn), .bus(b_if.master));
  ntru_result_reader #(.N(N_C), .q(2048), .M(2), .TDATA_W(32), .FIFO_DEPTH(4))
    u_c (.clk(clk), .resetn(resetn), .bus(c_if.master));
  ntru_result_reader #(.N(11),  .q(2048), .M(1), .TDATA_W(32), .FIFO_DEPTH(2))
    u_d (.clk(clk), .resetn(resetn), .bus(d_if.master));

  assign a_if.start = go && (sel == 0);
  assign b_if.start = go && (sel == 1);
  assign c_if.start = go && (sel == 2);
  assign d_if.start = go && (sel == 3);
  assign a_if.m_axis_tready = rdy;
  assign b_if.m_axis_tready = rdy;
  assign c_if.m_axis_tready = rdy;
  assign d_if.m_axis_tready = rdy;

  // Memory models: registered read data, garbage when read is not selected.
  always @(posedge clk) begin
    a_if.mem_eo <= a_if.mem_read ? (11'd100 + 11'(a_if.mem_addr)) : 11'h7ff;
    b_if.mem_eo <= b_if.mem_read ? 11'(b_if.mem_addr) : 11'h7ff;
    c_if.mem_eo <= c_if.mem_read ? (11'd3 * 11'(c_if.mem_addr) + 11'd7) : 11'h7ff;
    d_if.mem_eo <= d_if.mem_read ? (11'd500 + 11'(d_if.mem_addr)) : 11'h7ff;
  end

  logic [31:0] s_addr, s_dat;
  logic        s_vld, s_last, s_done, s_busy, s_read;

  always_comb begin
    s_addr = '0; s_dat = '0; s_vld = 1'b0; s_last = 1'b0;
    s_done = 1'b0; s_busy = 1'b0; s_read = 1'b0;
    case (sel)
      0: begin
        s_addr = 32'(a_if.mem_addr); s_dat = a_if.m_axis_tdata; s_vld = a_if.m_axis_tvalid;
        s_last = a_if.m_axis_tlast; s_done = a_if.done; s_busy = a_if.busy; s_read = a_if.mem_read;
      end
      1: begin
        s_addr = 32'(b_if.mem_addr); s_dat = b_if.m_axis_tdata; s_vld = b_if.m_axis_tvalid;
        s_last = b_if.m_axis_tlast; s_done = b_if.done; s_busy = b_if.busy; s_read = b_if.mem_read;
      end
      2: begin
        s_addr = 32'(c_if.mem_addr); s_dat = c_if.m_axis_tdata; s_vld = c_if.m_axis_tvalid;
        s_last = c_if.m_axis_tlast; s_done = c_if.done; s_busy = c_if.busy; s_read = c_if.mem_read;
      end
      3: begin
        s_addr = 32'(d_if.mem_addr); s_dat = d_if.m_axis_tdata; s_vld = d_if.m_axis_tvalid;
        s_last = d_if.m_axis_tlast; s_done = d_if.done; s_busy = d_if.busy; s_read = d_if.mem_read;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(s_busy), 0);
    chk({tag, "_done"}, 32'(s_done), 0);
    chk({tag, "_read"}, 32'(s_read), 0);
    chk({tag, "_addr"}, s_addr, 0);
    chk({tag, "_vld"},  32'(s_vld), 0);
    chk({tag, "_last"}, 32'(s_last), 0);
    chk({tag, "_dat"},  s_dat, 0);
  endtask

  // Short runs with tready held high: cycle c counts from the cycle after the start edge.
  task automatic run_short(input int s, input string nm, input int n, input int base);
    bit exp_v;
    sel = s;
    rdy = 1'b1;
    @(negedge clk); go = 1'b1;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk); go = 1'b0;
      if (c <= n) chk({nm, "_addr"}, s_addr, 32'(exp_addr[c-1]));
      exp_v = (c >= 3) && (c <= n + 2);
      chk({nm, "_vld"}, 32'(s_vld), 32'(exp_v));
      if (exp_v) begin
        chk({nm, "_dat"},  s_dat, 32'(base + exp_addr[c-3]));
        chk({nm, "_last"}, 32'(s_last), 32'(c == n + 2));
      end
      chk({nm, "_done"}, 32'(s_done), 32'(c == n + 3));
      chk({nm, "_busy"}, 32'(s_busy), 32'(c <= n + 2));
      chk({nm, "_read"}, 32'(s_read), 32'(c <= n + 2));
    end
  endtask

  // Long run on the N=541 reader; beat k must carry 3k+7.
  task automatic drain_c(input int duty, input int stop_at, input bit mid_start, input bit start_on_done);
    int k; int cyc; bit fin; bit stall; bit pulsed; logic [31:0] hold; logic hold_last;
    k = 0; cyc = 0; fin = 0; stall = 0; pulsed = 0; hold = '0; hold_last = 1'b0;
    while (!fin && cyc < 8000) begin
      @(negedge clk); cyc++; go = 1'b0;
      if (stall) begin
        chk("c_hold_vld",  32'(s_vld), 1);
        chk("c_hold_dat",  s_dat, hold);
        chk("c_hold_last", 32'(s_last), 32'(hold_last));
      end
      if (k == stop_at) begin
        fin = 1;
      end else if (k == N_C) begin
        chk("c_done", 32'(s_done), 1);
        chk("c_busy_at_done", 32'(s_busy), 0);
        fin = 1;
        go = start_on_done;
      end else begin
        rdy = ($urandom_range(0, 99) < duty);
        if (mid_start && !pulsed && k == 100) begin
          go = 1'b1; pulsed = 1;
        end
        if (s_vld && rdy) begin
          chk("c_dat",  s_dat, 32'(3 * k + 7));
          chk("c_last", 32'(s_last), 32'(k == N_C - 1));
          k++;
        end
        stall = s_vld && !rdy;
        hold = s_dat;
        hold_last = s_last;
      end
    end
    chk("c_finished", 32'(fin), 1);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i; #1;
      check_idle("rst");
    end
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) exp_addr[i] = i;
    run_short(0, "a", 5, 100);
    exp_addr = '{0, 1, 2, 4, 5, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_short(1, "b", 7, 0);
    for (int i = 0; i < 16; i++) exp_addr[i] = i;
    run_short(3, "d", 11, 500);

    sel = 2; rdy = 1'b0;
    @(negedge clk); go = 1'b1;
    drain_c(30, -1, 1'b1, 1'b1);
    drain_c(30, -1, 1'b0, 1'b0);

    @(negedge clk); go = 1'b1;
    drain_c(30, 200, 1'b0, 1'b0);
    rdy = 1'b0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    check_idle("mid_rst");
    @(negedge clk);
    chk("mid_rst_no_resume", 32'(s_vld), 0);
    go = 1'b1;
    drain_c(100, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
